// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: raw pad lines in, held scan code and frame strobes out.
// The receiver uses the master modport; the downstream consumer uses slave.
interface ps2_rx_if;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [7:0] code_o;
    logic       code_valid_o;
    logic       break_o;
    logic       parity_err_o;

    modport master (
        input  ps2_clk_i, ps2_data_i,
        output code_o, code_valid_o, break_o, parity_err_o
    );

    modport slave (
        output ps2_clk_i, ps2_data_i,
        input  code_o, code_valid_o, break_o, parity_err_o
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard frame receiver with clock glitch filter and idle watchdog.
// Define PS2_BREAK_FILTER_EN to absorb F0 break prefixes and clear code_o on key release.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic     clk,
    input  logic     rst,
    ps2_rx_if.master bus
);
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] filt_sh;
    logic                  filt;
    logic                  fall;
    logic [7:0]            shreg;
    logic [2:0]            bit_cnt;
    logic                  par_bit;
    logic [WDW-1:0]        wdog;
`ifdef PS2_BREAK_FILTER_EN
    logic                  brk_flag;
`endif

    logic data_bit;
    assign data_bit = dat_sync[1];

    // Synchronizers and clock filter; the filtered level only moves on unanimous samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_sh  <= '1;
            filt     <= 1'b1;
            fall     <= 1'b0;
        end else begin
            // NOTE: nonblocking assignments let each stage read the previous stage's old value.
            clk_sync <= {clk_sync[0], bus.ps2_clk_i};
            dat_sync <= {dat_sync[0], bus.ps2_data_i};
            filt_sh  <= {filt_sh[FILTER_LEN-2:0], clk_sync[1]};
            if (&filt_sh)
                filt <= 1'b1;
            else if (~|filt_sh)
                filt <= 1'b0;
            fall <= filt & ~|filt_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            shreg            <= 8'h00;
            bit_cnt          <= 3'd0;
            par_bit          <= 1'b0;
            wdog             <= '0;
            bus.code_o       <= 8'h00;
            bus.code_valid_o <= 1'b0;
            bus.break_o      <= 1'b0;
            bus.parity_err_o <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk_flag         <= 1'b0;
`endif
        end else begin
            bus.code_valid_o <= 1'b0;
            bus.break_o      <= 1'b0;
            bus.parity_err_o <= 1'b0;

            if (state == IDLE || fall)
                wdog <= '0;
            else if (wdog != WD_MAX)
                wdog <= wdog + 1'b1;

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            shreg   <= 8'h00;
                            bit_cnt <= 3'd0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^{shreg, par_bit}) && data_bit) begin
`ifdef PS2_BREAK_FILTER_EN
                            if (brk_flag) begin
                                brk_flag         <= 1'b0;
                                bus.code_valid_o <= 1'b1;
                                bus.break_o      <= 1'b1;
                                if (shreg == bus.code_o)
                                    bus.code_o <= 8'h00;
                            end else if (shreg == 8'hF0) begin
                                brk_flag <= 1'b1;
                            end else begin
                                bus.code_o       <= shreg;
                                bus.code_valid_o <= 1'b1;
                            end
`else
                            bus.code_o       <= shreg;
                            bus.code_valid_o <= 1'b1;
`endif
                        end else begin
                            bus.parity_err_o <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && wdog == WD_MAX) begin
                // Stalled frame: drop it without any strobe.
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames from the test plan followed by
// random frames, all compared against a frame-level reference model.
module tb_ps2_rx;
    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 40;

    logic clk;
    logic rst;
    ps2_rx_if bus ();

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    int cyc       = 0;
    int n_valid   = 0;
    int n_brk     = 0;
    int n_perr    = 0;
    int n_both    = 0;
    int n_long    = 0;
    int n_brk_solo = 0;
    int vcyc      = 0;
    int fall_cyc  = 0;
    logic prev_valid = 1'b0;
    logic prev_perr  = 1'b0;

    logic [7:0] m_code = 8'h00;
`ifdef PS2_BREAK_FILTER_EN
    bit m_brk = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_valid_o) begin
            n_valid = n_valid + 1;
            vcyc    = cyc;
        end
        if (bus.break_o) begin
            n_brk = n_brk + 1;
            if (!bus.code_valid_o) n_brk_solo = n_brk_solo + 1;
        end
        if (bus.parity_err_o) n_perr = n_perr + 1;
        if (bus.code_valid_o && bus.parity_err_o) n_both = n_both + 1;
        if ((bus.code_valid_o && prev_valid) || (bus.parity_err_o && prev_perr)) n_long = n_long + 1;
        prev_valid = bus.code_valid_o;
        prev_perr  = bus.parity_err_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first nbits bits of an 11-bit frame, data set mid-high, sampled on the low half.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data_i = bits[i];
            wait_cyc(HALF / 2);
            bus.ps2_clk_i = 1'b0;
            fall_cyc = cyc;
            wait_cyc(HALF);
            bus.ps2_clk_i = 1'b1;
            if (glitch) begin
                wait_cyc(8);
                bus.ps2_clk_i = 1'b0;
                wait_cyc(3);
                bus.ps2_clk_i = 1'b1;
                wait_cyc(HALF / 2 - 11);
            end else begin
                wait_cyc(HALF / 2);
            end
        end
        bus.ps2_data_i = 1'b1;
    endtask

    // Key-level behaviour: what a received byte does to the held code and the strobes.
    task automatic model_frame(input logic [7:0] b, input bit ok,
                               output int ev, output int eb, output int ep);
        ev = 0; eb = 0; ep = 0;
        if (!ok) begin
            ep = 1;
        end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (m_brk) begin
                m_brk = 1'b0;
                ev = 1;
                eb = 1;
                if (b == m_code) m_code = 8'h00;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                m_code = b;
                ev = 1;
            end
`else
            m_code = b;
            ev = 1;
`endif
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input bit glitch);
        int v0, p0, k0, ev, eb, ep;
        v0 = n_valid; p0 = n_perr; k0 = n_brk;
        model_frame(b, !(bad_par || bad_stop), ev, eb, ep);
        send_frame(b, bad_par, bad_stop, glitch, 11);
        wait_cyc(FL + 10);
        check({tag, ".valid"}, n_valid - v0, ev);
        check({tag, ".perr"},  n_perr - p0,  ep);
        check({tag, ".break"}, n_brk - k0,   eb);
        check({tag, ".code"},  {24'h0, bus.code_o}, {24'h0, m_code});
    endtask

    initial begin
        int v0, p0;
        logic [7:0] b;
        rst = 1'b1;
        bus.ps2_clk_i  = 1'b1;
        bus.ps2_data_i = 1'b1;
        wait_cyc(5);
        check("rst.code",  {24'h0, bus.code_o}, 32'h0);
        check("rst.valid", {31'h0, bus.code_valid_o}, 32'h0);
        check("rst.break", {31'h0, bus.break_o}, 32'h0);
        check("rst.perr",  {31'h0, bus.parity_err_o}, 32'h0);
        rst = 1'b0;
        wait_cyc(20);

        run_frame("f24", 8'h24, 1'b0, 1'b0, 1'b0);
        check("latency", vcyc - fall_cyc, FL + 4);

        run_frame("seq24", 8'h24, 1'b0, 1'b0, 1'b0);
        run_frame("seqF0", 8'hF0, 1'b0, 1'b0, 1'b0);
        run_frame("seq24r", 8'h24, 1'b0, 1'b0, 1'b0);

        // Restore a known held code before the parity test.
        run_frame("re24", 8'h24, 1'b0, 1'b0, 1'b0);
        run_frame("par4B", 8'h4B, 1'b1, 1'b0, 1'b0);
        run_frame("stop33", 8'h33, 1'b0, 1'b1, 1'b0);

        v0 = n_valid; p0 = n_perr;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 6);
        wait_cyc(TO + 10);
        check("tmo.valid", n_valid - v0, 0);
        check("tmo.perr",  n_perr - p0,  0);
        run_frame("tmo5A", 8'h5A, 1'b0, 1'b0, 1'b0);

        run_frame("glitch1D", 8'h1D, 1'b0, 1'b0, 1'b1);

        send_frame(8'h23, 1'b0, 1'b0, 1'b0, 5);
        wait_cyc(5);
        rst = 1'b1;
        @(negedge clk);
        check("mrst.code",  {24'h0, bus.code_o}, 32'h0);
        check("mrst.valid", {31'h0, bus.code_valid_o}, 32'h0);
        check("mrst.break", {31'h0, bus.break_o}, 32'h0);
        check("mrst.perr",  {31'h0, bus.parity_err_o}, 32'h0);
        rst = 1'b0;
        m_code = 8'h00;
`ifdef PS2_BREAK_FILTER_EN
        m_brk = 1'b0;
`endif
        wait_cyc(20);
        run_frame("mrst2D", 8'h2D, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0)
                b = 8'hF0;
            else if ($urandom_range(0, 2) == 0)
                b = m_code;
            else
                b = 8'($urandom);
            run_frame($sformatf("rnd%0d", i), b, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end

        check("both_high",  n_both, 0);
        check("long_pulse", n_long, 0);
        check("break_solo", n_brk_solo, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receives the PS/2 keyboard serial stream and delivers complete, parity-checked scan codes to the key decoder stage. It sits directly upstream of the scan-code-to-one-hot decoder and drives that decoder's 8-bit code input. The block holds the code of the currently pressed key on its output and clears it to 8'h00 on release. It also provides a one-cycle strobe per received frame.

## Interface
- FILTER_LEN, 8: number of consecutive identical samples needed before the filtered PS/2 clock changes level (2..16).
- TIMEOUT, 100000: idle `clk` cycles inside a frame before the frame is discarded (≥ 2).
- clk  in  1  system clock (100 MHz), the only clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk_i  in  1  raw PS/2 clock from pad, asynchronous.
- ps2_data_i  in  1  raw PS/2 data from pad, asynchronous.
- code_o  out  8  held scan code. Feeds the decoder's `code_i`.
- code_valid_o  out  1  one-cycle pulse when a frame is accepted.
- break_o  out  1  one-cycle pulse, coincident with code_valid_o, when the accepted frame completes a break sequence.
- parity_err_o  out  1  one-cycle pulse when a frame fails the parity or stop check.

## Operation
- ps2_clk_i and ps2_data_i each pass through a 2-FF synchronizer.
- The synchronized clock feeds a FILTER_LEN-deep shift register. The filtered level changes only when all FILTER_LEN samples agree.
- A falling edge of the filtered clock generates a one-cycle `fall` tick. Data is sampled from the synchronized data on `fall`.
- FSM states are IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), clear the shift register and bit counter, then go to DATA. On `fall` with data=1, stay in IDLE.
  - DATA: on each `fall`, shift data in LSB first and increment the 3-bit counter. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good only if the 8 data bits plus the parity bit contain an odd number of ones and the stop bit is 1. Return to IDLE in all cases.
- On a good frame, pulse code_valid_o and update code_o as described under Configuration.
- On a bad frame, pulse parity_err_o. code_o and code_valid_o do not change.
- Watchdog counter:
  - Clears on every `fall` and while in IDLE, and increments otherwise.
  - When it reaches TIMEOUT-1 outside IDLE, the FSM returns to IDLE and the partial frame is dropped silently (no pulse).
  - The counter saturates and never wraps.
- When `fall` and the timeout occur in the same cycle, `fall` wins and the watchdog clears.
- rst, including mid-frame:
  - FSM to IDLE; bit counter, watchdog and break flag cleared.
  - code_o = 8'h00; code_valid_o, break_o and parity_err_o all 0.
  - Filter shift register loaded with all ones, so the filtered clock is 1.

## Timing
- The `fall` tick asserts exactly FILTER_LEN+3 `clk` cycles after ps2_clk_i falls cleanly: 2 cycles synchronizer, FILTER_LEN cycles filter, 1 cycle edge detect.
- code_o, code_valid_o, break_o and parity_err_o are registered. They update on the `clk` edge that follows the `fall` tick for the stop bit.
- code_o is stable between frames. The downstream decoder may sample it at any rate.
- Pulses on code_valid_o, break_o and parity_err_o last exactly one cycle.
- code_valid_o and parity_err_o are never high together.
- Level changes on ps2_clk_i shorter than FILTER_LEN cycles are ignored.

## Configuration
- Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - A good frame of 8'hF0 sets an internal break flag. It gives no code_valid_o pulse and leaves code_o unchanged.
  - The next good frame clears the flag and pulses code_valid_o together with break_o.
  - On that frame, code_o becomes 8'h00 if the released code equals the held code_o; otherwise code_o is unchanged.
  - A good frame that is not F0, received with the flag clear, loads code_o and pulses code_valid_o, with break_o=0.
- Undefined:
  - Every good frame, 8'hF0 included, loads code_o with the raw byte and pulses code_valid_o.
  - break_o is tied to 0 and the break flag logic is absent.

## Test plan
- Reset, then frame 0x24 (data LSB first 0,0,1,0,0,1,0,0; parity 1; stop 1; PS/2 clock period 80 µs) → code_o=8'h24, one code_valid_o pulse, break_o=0.
- With PS2_BREAK_FILTER_EN defined: frames 0x24, F0, 24 → code_valid_o pulses twice; on the second pulse break_o=1 and code_o=8'h00. With the macro undefined, the same frames → three pulses and final code_o=8'h24.
- Frame 0x4B sent with parity bit 0 → parity_err_o pulses once, no code_valid_o, code_o keeps its prior value 8'h24.
- Start bit plus 5 data bits, then ps2_clk_i held high for TIMEOUT+10 cycles, then full frame 0x5A (parity 1) → no pulse from the partial frame, then code_o=8'h5A with one code_valid_o pulse.
- 3-cycle low glitches on ps2_clk_i (FILTER_LEN=8) inserted between the bits of frame 0x1D → the glitches are ignored and code_o=8'h1D.
- rst asserted for one cycle after the 4th data bit of frame 0x23 → all outputs 0, FSM in IDLE; the following frame 0x2D is received correctly.
